instr_prefetch_buffer: RTL and testbench

- Fetch-side master for sp_ram: issues word-aligned sequential read requests over the req/gnt/rvalid interface.
- Buffers returned words in a small FIFO and presents them to the core through a valid/ready port.
- Supports branch redirect with flush; responses still in flight from the old stream are discarded.
- Sits between the core fetch stage and sp_ram (instruction port).

---
 rtl/instr_prefetch_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_instr_prefetch_buffer.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_prefetch_buffer
// Sequential instruction prefetcher between the core fetch stage and the
// sp_ram instruction port. Issues word-aligned read requests over
// req/gnt/rvalid, buffers returned words in a small FIFO and hands them to the
// core over a valid/ready port. A branch redirect flushes the FIFO and marks
// every response still in flight from the old stream for discard.
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a response arriving while the FIFO is empty (and nothing is
//   being discarded) is forwarded combinationally to the core port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   fetch_enable_i    permits new memory requests
//   branch_i          one-cycle redirect pulse, branch_addr_i is the target
//   fetch_valid_o     head word available (fetch_rdata_o / fetch_addr_o)
//   fetch_ready_i     core consumes the head word
//   instr_req_o       memory request, instr_addr_o word aligned
//   instr_be_o        byte enables (all ones), instr_we_o constant 0
//   instr_gnt_i       request accepted
//   instr_rvalid_i    read data valid, instr_rdata_i the data
//   busy_o            responses outstanding or pending discard
// -----------------------------------------------------------------------------
module instr_prefetch_buffer #(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           DEPTH           = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = ADDR_WIDTH'(32'h80)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_enable_i,
    input  logic                    branch_i,
    input  logic [ADDR_WIDTH-1:0]   branch_addr_i,
    output logic                    fetch_valid_o,
    input  logic                    fetch_ready_i,
    output logic [DATA_WIDTH-1:0]   fetch_rdata_o,
    output logic [ADDR_WIDTH-1:0]   fetch_addr_o,
    output logic                    instr_req_o,
    output logic [ADDR_WIDTH-1:0]   instr_addr_o,
    output logic [DATA_WIDTH/8-1:0] instr_be_o,
    output logic                    instr_we_o,
    input  logic                    instr_gnt_i,
    input  logic                    instr_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   instr_rdata_i,
    output logic                    busy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] BOOT_ALIGN = BOOT_ADDR & ALIGN_MASK;

    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic [ADDR_WIDTH-1:0] head_addr_q;
    logic                  req_hold_q;
    logic                  br_pend_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [OUT_W-1:0]      outstanding_q;
    logic [OUT_W-1:0]      discard_q;

    logic [ADDR_WIDTH-1:0] target;
    logic [SUM_W-1:0]      used;
    logic                  credit_ok;
    logic                  req_c;
    logic                  gnt_c;
    logic                  rsp_c;
    logic                  drop_c;
    logic                  keep_c;
    logic                  fifo_empty;
    logic                  byp_c;
    logic                  byp_take_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  valid_c;

    assign target = branch_addr_i & ALIGN_MASK;

    // Slots already promised: buffered words plus live (non-discarded) reads.
    assign used      = SUM_W'(count_q) + SUM_W'(outstanding_q) - SUM_W'(discard_q);
    assign credit_ok = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) && (used < SUM_W'(DEPTH));

    // A raised request is held until granted, regardless of enable or branch.
    assign req_c = req_hold_q | (fetch_enable_i & credit_ok);
    assign gnt_c = req_c & instr_gnt_i;

    // Responses with nothing outstanding are protocol errors and ignored.
    assign rsp_c  = instr_rvalid_i & (outstanding_q != '0);
    assign drop_c = rsp_c & ((discard_q != '0) | branch_i);
    assign keep_c = rsp_c & ~drop_c;

    assign fifo_empty = (count_q == '0);

`ifdef PREFETCH_BYPASS_EN
    assign byp_c = keep_c & fifo_empty;
`else
    assign byp_c = 1'b0;
`endif

    assign byp_take_c = byp_c & fetch_ready_i;
    assign push_c     = keep_c & ~byp_take_c;
    assign pop_c      = ~branch_i & fetch_ready_i & ~fifo_empty;
    assign valid_c    = ~fifo_empty | byp_c;

    // Request side: address, hold and redirect bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q    <= BOOT_ALIGN;
            pend_addr_q   <= BOOT_ALIGN;
            req_hold_q    <= 1'b0;
            br_pend_q     <= 1'b0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            req_hold_q    <= req_c & ~instr_gnt_i;
            outstanding_q <= outstanding_q + OUT_W'(gnt_c) - OUT_W'(rsp_c);

            if (branch_i) begin
                // Everything in flight now, including a grant this cycle, is stale.
                discard_q <= outstanding_q + OUT_W'(gnt_c) - OUT_W'(rsp_c);
            end else if (br_pend_q && gnt_c) begin
                // The held pre-branch request finally granted: its data is stale too.
                discard_q <= discard_q + OUT_W'(1) - OUT_W'(drop_c);
            end else if (drop_c) begin
                discard_q <= discard_q - OUT_W'(1);
            end

            if (branch_i) begin
                if (req_c && !instr_gnt_i) begin
                    br_pend_q   <= 1'b1;
                    pend_addr_q <= target;
                end else begin
                    br_pend_q  <= 1'b0;
                    req_addr_q <= target;
                end
            end else if (gnt_c) begin
                if (br_pend_q) begin
                    br_pend_q  <= 1'b0;
                    req_addr_q <= pend_addr_q;
                end else begin
                    req_addr_q <= req_addr_q + STEP;
                end
            end
        end
    end

    // FIFO pointers, occupancy and head address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            head_addr_q <= BOOT_ALIGN;
        end else if (branch_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            head_addr_q <= target;
        end else begin
            if (push_c) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (pop_c || byp_take_c) begin
                head_addr_q <= head_addr_q + STEP;
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wptr_q] <= instr_rdata_i;
        end
    end

    // Core port; address and data read as zero while nothing is valid.
    assign fetch_valid_o = valid_c;
    assign fetch_addr_o  = valid_c ? head_addr_q : '0;
`ifdef PREFETCH_BYPASS_EN
    assign fetch_rdata_o = byp_c ? instr_rdata_i : (valid_c ? mem_q[rptr_q] : '0);
`else
    assign fetch_rdata_o = valid_c ? mem_q[rptr_q] : '0;
`endif

    // Memory port.
    assign instr_req_o  = req_c;
    assign instr_addr_o = req_c ? req_addr_q : '0;
    assign instr_be_o   = '1;
    assign instr_we_o   = 1'b0;

    assign busy_o = (outstanding_q != '0) || (discard_q != '0);

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_prefetch_buffer
// Directed bench for instr_prefetch_buffer. A memory stub answers requests
// with a configurable grant delay and response latency; memory word at byte
// address A is 32'hA000_0000 ^ A. A monitor records every word the core
// consumes. Stimulus is driven on the falling edge; the stub acts 1 time unit
// later and the monitor samples 2 time units later.
// -----------------------------------------------------------------------------
module tb_instr_prefetch_buffer;

`ifdef PREFETCH_BYPASS_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_enable_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        fetch_ready_i = 1'b0;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        fetch_valid_o;
    logic [31:0] fetch_rdata_o;
    logic [31:0] fetch_addr_o;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic [3:0]  instr_be_o;
    logic        instr_we_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // memory stub / monitor state
    int          gnt_delay = 0;
    int          rsp_lat = 1;
    int          gwait = 0;
    int          cyc = 0;
    int          model_outs = 0;
    int          max_outs = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];
    logic [31:0] gnt_log[$];
    logic [31:0] del_addr[$];
    logic [31:0] del_data[$];
    int          br_cyc = 0;
    int          first_valid_cyc = 0;
    logic        br_gnt = 1'b0;
    logic        br_rvalid = 1'b0;

    instr_prefetch_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable_i (fetch_enable_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .fetch_valid_o  (fetch_valid_o),
        .fetch_ready_i  (fetch_ready_i),
        .fetch_rdata_o  (fetch_rdata_o),
        .fetch_addr_o   (fetch_addr_o),
        .instr_req_o    (instr_req_o),
        .instr_addr_o   (instr_addr_o),
        .instr_be_o     (instr_be_o),
        .instr_we_o     (instr_we_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .busy_o         (busy_o)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 ^ a;
    endfunction

    // Memory stub and consumer monitor.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            instr_gnt_i = 1'b0;
            if (instr_req_o) begin
                if (gwait >= gnt_delay) begin
                    instr_gnt_i = 1'b1;
                    gwait = 0;
                    q_addr.push_back(instr_addr_o);
                    q_due.push_back(cyc + rsp_lat);
                    gnt_log.push_back(instr_addr_o);
                end else begin
                    gwait++;
                end
            end else begin
                gwait = 0;
            end
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = 32'hDEAD_BEEF;
            end
            if (instr_gnt_i) model_outs++;
            if (instr_rvalid_i && model_outs > 0) model_outs--;
            if (model_outs > max_outs) max_outs = model_outs;
            if (branch_i) begin
                br_cyc          = cyc;
                first_valid_cyc = -1;
                br_gnt          = instr_gnt_i;
                br_rvalid       = instr_rvalid_i;
            end
            #1;
            if (fetch_valid_o && !branch_i && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (fetch_valid_o && fetch_ready_i && !branch_i) begin
                del_addr.push_back(fetch_addr_o);
                del_data.push_back(fetch_rdata_o);
            end
        end
    end

    task automatic do_reset(input int gd, input int lat);
        @(negedge clk);
        rst_n = 1'b0;
        fetch_enable_i = 1'b0;
        branch_i = 1'b0;
        branch_addr_i = '0;
        fetch_ready_i = 1'b0;
        gnt_delay = gd;
        rsp_lat = lat;
        gwait = 0;
        model_outs = 0;
        max_outs = 0;
        q_addr.delete();
        q_due.delete();
        gnt_log.delete();
        del_addr.delete();
        del_data.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fetch_enable_i = 1'b0;
        fetch_ready_i = 1'b0;
        #1;
        checks++;
        if (fetch_valid_o !== 1'b0 || fetch_addr_o !== 32'h0 || fetch_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch: valid=%b addr=%h data=%h expected 0/0/0", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
        end
        checks++;
        if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0 || instr_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem: req=%b addr=%h we=%b expected 0/0/0", instr_req_o, instr_addr_o, instr_we_o);
        end
        checks++;
        if (instr_be_o !== 4'hF) begin
            errors++;
            $display("FAIL reset_be: got %h expected f", instr_be_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_enable_i = 1'b1;
        #1;
        checks++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            errors++;
            $display("FAIL boot_req: req=%b addr=%h expected 1/00000080", instr_req_o, instr_addr_o);
        end
    endtask

    task automatic test_sequential();
        do_reset(0, 2);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b1;
        repeat (14) @(negedge clk);
        checks++;
        if (gnt_log.size() < 3) begin
            errors++;
            $display("FAIL seq_gnt_count: got %0d expected >=3", gnt_log.size());
        end else if (gnt_log[0] !== 32'h80 || gnt_log[1] !== 32'h84 || gnt_log[2] !== 32'h88) begin
            errors++;
            $display("FAIL seq_gnt_addr: got %h %h %h expected 80 84 88", gnt_log[0], gnt_log[1], gnt_log[2]);
        end
        checks++;
        if (del_addr.size() < 4) begin
            errors++;
            $display("FAIL seq_del_count: got %0d expected >=4", del_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (del_addr[i] !== 32'h80 + 32'(4 * i) || del_data[i] !== 32'hA000_0080 + 32'(4 * i)) begin
                    errors++;
                    $display("FAIL seq_word%0d: got %h/%h expected %h/%h", i, del_addr[i], del_data[i],
                             32'h80 + 32'(4 * i), 32'hA000_0080 + 32'(4 * i));
                end
            end
        end
        checks++;
        if (max_outs !== 2) begin
            errors++;
            $display("FAIL seq_max_outstanding: got %0d expected 2", max_outs);
        end
    endtask

    task automatic test_backpressure();
        do_reset(0, 1);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (gnt_log.size() !== 4) begin
            errors++;
            $display("FAIL bp_gnt_count: got %0d expected 4", gnt_log.size());
        end
        checks++;
        if (instr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_req_low: got %b expected 0", instr_req_o);
        end
        checks++;
        if (fetch_valid_o !== 1'b1 || fetch_addr_o !== 32'h80 || fetch_rdata_o !== 32'hA000_0080) begin
            errors++;
            $display("FAIL bp_head: got %b/%h/%h expected 1/00000080/a0000080", fetch_valid_o, fetch_addr_o, fetch_rdata_o);
        end
        fetch_ready_i = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (gnt_log.size() < 5) begin
            errors++;
            $display("FAIL bp_resume_count: got %0d expected >=5", gnt_log.size());
        end else if (gnt_log[4] !== 32'h90) begin
            errors++;
            $display("FAIL bp_resume_addr: got %h expected 00000090", gnt_log[4]);
        end
        checks++;
        if (del_addr.size() < 5) begin
            errors++;
            $display("FAIL bp_del_count: got %0d expected >=5", del_addr.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (del_addr[i] !== 32'h80 + 32'(4 * i) || del_data[i] !== word(32'h80 + 32'(4 * i))) begin
                    errors++;
                    $display("FAIL bp_word%0d: got %h/%h expected %h", i, del_addr[i], del_data[i], 32'h80 + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_branch_outstanding();
        int gsz;
        bit found;
        do_reset(0, 3);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (model_outs == 2) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL bro_reach_two: outstanding never reached 2 within 20 cycles");
        end
        branch_i = 1'b1;
        branch_addr_i = 32'hC6;
        gsz = gnt_log.size();
        del_addr.delete();
        del_data.delete();
        @(negedge clk);
        branch_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || fetch_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bro_after_branch: busy=%b valid=%b expected 1/0", busy_o, fetch_valid_o);
        end
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL bro_busy_hold: got %b expected 1", busy_o);
        end
        repeat (12) @(negedge clk);
        checks++;
        if (gnt_log.size() <= gsz || gnt_log[gsz] !== 32'hC4) begin
            errors++;
            $display("FAIL bro_next_req: got %h expected 000000c4", (gnt_log.size() > gsz) ? gnt_log[gsz] : 32'hX);
        end
        checks++;
        if (del_addr.size() < 2) begin
            errors++;
            $display("FAIL bro_del_count: got %0d expected >=2", del_addr.size());
        end else if (del_addr[0] !== 32'hC4 || del_data[0] !== 32'hA000_00C4 || del_addr[1] !== 32'hC8) begin
            errors++;
            $display("FAIL bro_first_word: got %h/%h then %h expected 000000c4/a00000c4 then 000000c8",
                     del_addr[0], del_data[0], del_addr[1]);
        end
    endtask

    task automatic test_gnt_delay_branch();
        int bad;
        do_reset(3, 1);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b1;
        @(negedge clk);
        branch_i = 1'b1;
        branch_addr_i = 32'h200;
        fetch_enable_i = 1'b0;
        @(negedge clk);
        branch_i = 1'b0;
        #1;
        checks++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h80) begin
            errors++;
            $display("FAIL gdb_hold: req=%b addr=%h expected 1/00000080", instr_req_o, instr_addr_o);
        end
        repeat (3) @(negedge clk);
        fetch_enable_i = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (gnt_log.size() < 2 || gnt_log[0] !== 32'h80 || gnt_log[1] !== 32'h200) begin
            errors++;
            $display("FAIL gdb_gnt_order: got %0d grants, first %h second %h expected 00000080 00000200",
                     gnt_log.size(), (gnt_log.size() > 0) ? gnt_log[0] : 32'hX, (gnt_log.size() > 1) ? gnt_log[1] : 32'hX);
        end
        checks++;
        if (del_addr.size() < 1 || del_addr[0] !== 32'h200 || del_data[0] !== word(32'h200)) begin
            errors++;
            $display("FAIL gdb_first_word: got %0d words, first %h expected 00000200",
                     del_addr.size(), (del_addr.size() > 0) ? del_addr[0] : 32'hX);
        end
        bad = 0;
        foreach (del_addr[i]) if (del_addr[i] < 32'h200 || del_data[i] !== word(del_addr[i])) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gdb_stale_words: got %0d bad words expected 0", bad);
        end
    endtask

    task automatic test_branch_same_cycle();
        int gsz;
        int bad;
        do_reset(0, 1);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        branch_i = 1'b1;
        branch_addr_i = 32'h300;
        gsz = gnt_log.size();
        del_addr.delete();
        del_data.delete();
        @(negedge clk);
        branch_i = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (br_gnt !== 1'b1 || br_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL bsc_overlap: gnt=%b rvalid=%b in branch cycle expected 1/1", br_gnt, br_rvalid);
        end
        checks++;
        if (gnt_log.size() <= gsz + 1 || gnt_log[gsz + 1] !== 32'h300) begin
            errors++;
            $display("FAIL bsc_next_req: got %h expected 00000300", (gnt_log.size() > gsz + 1) ? gnt_log[gsz + 1] : 32'hX);
        end
        checks++;
        if (first_valid_cyc - br_cyc !== EXP_LAT) begin
            errors++;
            $display("FAIL bsc_latency: got %0d expected %0d", first_valid_cyc - br_cyc, EXP_LAT);
        end
        checks++;
        if (del_addr.size() < 3 || del_addr[0] !== 32'h300 || del_data[0] !== word(32'h300)) begin
            errors++;
            $display("FAIL bsc_first_word: got %0d words, first %h expected 00000300",
                     del_addr.size(), (del_addr.size() > 0) ? del_addr[0] : 32'hX);
        end
        bad = 0;
        foreach (del_addr[i]) begin
            if (del_addr[i] !== 32'h300 + 32'(4 * i) || del_data[i] !== word(del_addr[i])) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bsc_order: got %0d out-of-order or stale words expected 0", bad);
        end
    endtask

    task automatic test_wrap();
        int gsz;
        int idx;
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        exp_a[3] = 32'h0000_0004;
        do_reset(0, 1);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        branch_i = 1'b1;
        branch_addr_i = 32'hFFFF_FFF8;
        gsz = gnt_log.size();
        del_addr.delete();
        del_data.delete();
        @(negedge clk);
        branch_i = 1'b0;
        repeat (10) @(negedge clk);
        idx = gsz + int'(br_gnt);
        checks++;
        if (gnt_log.size() < idx + 4) begin
            errors++;
            $display("FAIL wrap_gnt_count: got %0d expected >=%0d", gnt_log.size(), idx + 4);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gnt_log[idx + i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL wrap_req%0d: got %h expected %h", i, gnt_log[idx + i], exp_a[i]);
                end
            end
        end
        checks++;
        if (del_addr.size() < 4) begin
            errors++;
            $display("FAIL wrap_del_count: got %0d expected >=4", del_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (del_addr[i] !== exp_a[i] || del_data[i] !== word(exp_a[i])) begin
                    errors++;
                    $display("FAIL wrap_word%0d: got %h/%h expected %h/%h", i, del_addr[i], del_data[i], exp_a[i], word(exp_a[i]));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(0, 3);
        fetch_enable_i = 1'b1;
        fetch_ready_i = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        fetch_enable_i = 1'b0;
        model_outs = 0;
        del_addr.delete();
        del_data.delete();
        #1;
        checks++;
        if (busy_o !== 1'b0 || fetch_valid_o !== 1'b0 || instr_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async: busy=%b valid=%b req=%b expected 0/0/0", busy_o, fetch_valid_o, instr_req_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // stray response arriving after reset release with nothing outstanding
        q_addr.push_back(32'h80);
        q_due.push_back(0);
        repeat (6) @(negedge clk);
        checks++;
        if (del_addr.size() !== 0 || fetch_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rmid_late_rvalid: words=%0d valid=%b busy=%b expected 0/0/0", del_addr.size(), fetch_valid_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch_outstanding();
        test_gnt_delay_branch();
        test_branch_same_cycle();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
